// File: rtl/mul_div_unit_if.sv
// Feed and common-data-bus signals between the MUL/DIV reservation station,
// the CDB arbiter and the iterative mul/div execution unit.
//   master : station/arbiter side (drives feed_*, delete_tag, cdb_grant)
//   slave  : execution unit side (drives next, busy, cdb_request/result/rrn)
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            delete_tag;
    logic            feed_valid;
    logic [2:0]      feed_op;
    logic [XLEN-1:0] feed_data_1;
    logic [XLEN-1:0] feed_data_2;
    logic [5:0]      feed_rrn;
    logic            feed_tag;
    logic            next;
    logic            busy;
    logic            cdb_request;
    logic            cdb_grant;
    logic [XLEN-1:0] cdb_result;
    logic [5:0]      cdb_rrn;

    modport master (
        output delete_tag, feed_valid, feed_op, feed_data_1, feed_data_2,
               feed_rrn, feed_tag, cdb_grant,
        input  next, busy, cdb_request, cdb_result, cdb_rrn
    );

    modport slave (
        input  delete_tag, feed_valid, feed_op, feed_data_1, feed_data_2,
               feed_rrn, feed_tag, cdb_grant,
        output next, busy, cdb_request, cdb_result, cdb_rrn
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M execution unit. Takes one instruction from the MUL/DIV
// reservation station, runs a 32-step shift-add multiply or restoring
// divide over operand magnitudes, then holds the result on the CDB
// request/grant handshake. Speculative (tag=1) work is dropped on delete_tag.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : mul_div_unit_if.slave (feed bus, next/busy, CDB handshake, delete_tag)
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic          clock,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(STEPS);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   counter;
    logic [2:0]      op_q;
    logic            tag_q;
    logic            neg_q;
    logic [XLEN-1:0] hi, lo, b;
    logic [XLEN-1:0] hi_nx, lo_nx;
    logic [XLEN:0]   sum, shifted, diff;
    logic [XLEN-1:0] result_q;
    logic [5:0]      rrn_q;

    logic            accept, flush;
    logic            a_neg, b_neg, abs_1, abs_2, neg_in;
    logic [XLEN-1:0] mag_1, mag_2;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_val;

    // Applies the recorded sign to the finished magnitude and selects the
    // architectural result: {hi,lo} is the 64-bit product for multiplies,
    // and remainder/quotient for divides.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0]      op,
                                                 input logic            neg,
                                                 input logic [XLEN-1:0] h,
                                                 input logic [XLEN-1:0] l);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   res;
        prod = neg ? -{h, l} : {h, l};
        case (op)
            OP_MUL:                      res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             res = neg ? -l : l;
            default:                     res = neg ? -h : h;
        endcase
        return res;
    endfunction

    // Operand preparation at accept: magnitudes, result sign, fast-path cases.
    always_comb begin
        a_neg  = bus.feed_data_1[XLEN-1];
        b_neg  = bus.feed_data_2[XLEN-1];
        abs_1  = 1'b0;
        abs_2  = 1'b0;
        neg_in = 1'b0;
        case (bus.feed_op)
            OP_MULH, OP_DIV: begin
                abs_1  = a_neg;
                abs_2  = b_neg;
                neg_in = a_neg ^ b_neg;
            end
            OP_MULHSU: begin
                abs_1  = a_neg;
                neg_in = a_neg;
            end
            OP_REM: begin
                // Remainder follows the dividend's sign only.
                abs_1  = a_neg;
                abs_2  = b_neg;
                neg_in = a_neg;
            end
            default: ;
        endcase
        mag_1 = abs_1 ? -bus.feed_data_1 : bus.feed_data_1;
        mag_2 = abs_2 ? -bus.feed_data_2 : bus.feed_data_2;

        div_zero = (bus.feed_data_2 == '0);
        div_ovf  = ((bus.feed_op == OP_DIV) || (bus.feed_op == OP_REM)) &&
                   (bus.feed_data_1 == INT_MIN) && (bus.feed_data_2 == '1);
        fast     = bus.feed_op[2] && (div_zero || div_ovf);
        // feed_op[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero) fast_val = bus.feed_op[1] ? bus.feed_data_1 : '1;
        else          fast_val = bus.feed_op[1] ? '0 : INT_MIN;
    end

    // One iteration: multiply adds b into the upper half when the current
    // multiplier bit is set and shifts {hi,lo} right; divide shifts the next
    // dividend bit into the partial remainder and subtracts when it fits.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b};
        if (!op_q[2]) begin
            hi_nx = sum[XLEN:1];
            lo_nx = {sum[0], lo[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            hi_nx = diff[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_nx = shifted[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], 1'b0};
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        accept   = reset && bus.feed_valid && (state == IDLE) &&
                   !(bus.delete_tag && bus.feed_tag);
        flush    = (state != IDLE) && bus.delete_tag && tag_q;
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = fast ? DONE : BUSY;
            BUSY: begin
                if (flush)               state_nx = IDLE;
                else if (counter == '0)  state_nx = DONE;
            end
            DONE: if (flush || bus.cdb_grant) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        bus.next        = accept;
        bus.busy        = (state != IDLE);
        bus.cdb_request = (state == DONE);
    end

    assign bus.cdb_result = result_q;
    assign bus.cdb_rrn    = rrn_q;

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            counter  <= '0;
            tag_q    <= 1'b0;
            result_q <= '0;
            rrn_q    <= '0;
        end else if (accept) begin
            op_q    <= bus.feed_op;
            tag_q   <= bus.feed_tag;
            neg_q   <= neg_in;
            rrn_q   <= bus.feed_rrn;
            counter <= CW'(STEPS - 1);
            hi      <= '0;
            lo      <= mag_1;
            b       <= mag_2;
            if (fast) result_q <= fast_val;
        end else if (state == BUSY) begin
            hi      <= hi_nx;
            lo      <= lo_nx;
            counter <= counter - 1'b1;
            if (counter == '0) result_q <= finalize(op_q, neg_q, hi_nx, lo_nx);
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32), .STEPS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  rrn;
        logic [31:0] res;
        int          lat;
        int          gdly;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf)    return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return 33;
    endfunction

    // Entered just after a negedge with the unit idle; leaves it idle.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] rrn, input int gdly,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bus.feed_valid  = 1'b1;
        bus.feed_op     = op;
        bus.feed_data_1 = a;
        bus.feed_data_2 = b;
        bus.feed_rrn    = rrn;
        bus.feed_tag    = 1'b0;
        #1;
        chk({nm, ".next"}, 32'(bus.next), 32'd1);
        @(negedge clock);
        bus.feed_valid = 1'b0;
        lat = 1;
        while (!bus.cdb_request && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk({nm, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, ".result"}, bus.cdb_result, exp_res);
        chk({nm, ".rrn"}, 32'(bus.cdb_rrn), 32'(rrn));
        for (int k = 0; k < gdly; k++) begin
            bus.feed_valid = 1'b1;
            #1;
            chk({nm, ".next_in_done"}, 32'(bus.next), 32'd0);
            @(negedge clock);
            chk({nm, ".hold_request"}, 32'(bus.cdb_request), 32'd1);
            chk({nm, ".hold_result"}, bus.cdb_result, exp_res);
        end
        bus.feed_valid = 1'b0;
        bus.cdb_grant  = 1'b1;
        @(negedge clock);
        bus.cdb_grant = 1'b0;
        chk({nm, ".released_request"}, 32'(bus.cdb_request), 32'd0);
        chk({nm, ".released_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic feed(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] rrn, input logic tag);
        bus.feed_valid  = 1'b1;
        bus.feed_op     = op;
        bus.feed_data_1 = a;
        bus.feed_data_2 = b;
        bus.feed_rrn    = rrn;
        bus.feed_tag    = tag;
        @(negedge clock);
        bus.feed_valid = 1'b0;
        bus.feed_tag   = 1'b0;
    endtask

    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [5:0]  r_rrn;
    bit          seen;
    int          lat;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 6'd5,  32'hFFFFFFEB, 33, 0};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1,  32'hFFFFFFFE, 33, 0};
        vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2,  32'h00000000, 33, 0};
        vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        6'd3,  32'hFFFFFFFD, 33, 5};
        vecs[4]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        6'd4,  32'hFFFFFFFF, 33, 0};
        vecs[5]  = '{3'd5, 32'd10,       32'd0,        6'd6,  32'hFFFFFFFF, 1,  0};
        vecs[6]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 6'd7,  32'h00000000, 1,  0};
        vecs[7]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 6'd8,  32'h80000000, 1,  2};
        vecs[8]  = '{3'd7, 32'd10,       32'd0,        6'd9,  32'd10,       1,  0};
        vecs[9]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        6'd10, 32'hFFFFFFFF, 33, 0};
        vecs[10] = '{3'd5, 32'd100,      32'd7,        6'd11, 32'd14,       33, 0};
        vecs[11] = '{3'd7, 32'd100,      32'd7,        6'd12, 32'd2,        33, 0};
        vecs[12] = '{3'd0, 32'd3,        32'd4,        6'd13, 32'd12,       33, 0};
        vecs[13] = '{3'd1, 32'h80000000, 32'h80000000, 6'd14, 32'h40000000, 33, 0};
        vecs[14] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 6'd15, 32'h80000000, 33, 0};
        vecs[15] = '{3'd4, 32'd7,        32'hFFFFFFFE, 6'd16, 32'hFFFFFFFD, 33, 0};
        vecs[16] = '{3'd6, 32'd7,        32'hFFFFFFFE, 6'd17, 32'd1,        33, 0};

        reset           = 1'b0;
        bus.delete_tag  = 1'b0;
        bus.feed_valid  = 1'b1;
        bus.feed_op     = 3'd0;
        bus.feed_data_1 = 32'd1;
        bus.feed_data_2 = 32'd1;
        bus.feed_rrn    = 6'd1;
        bus.feed_tag    = 1'b0;
        bus.cdb_grant   = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset.next", 32'(bus.next), 32'd0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.request", 32'(bus.cdb_request), 32'd0);
        chk("reset.result", bus.cdb_result, 32'd0);
        chk("reset.rrn", 32'(bus.cdb_rrn), 32'd0);
        bus.feed_valid = 1'b0;
        reset          = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 17; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rrn,
                  vecs[i].gdly, vecs[i].res, vecs[i].lat);

        for (int i = 0; i < 150; i++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_a   = $urandom;
            r_b   = $urandom;
            r_rrn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = $urandom_range(1, 15);
                2: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
                3: r_a = $urandom_range(0, 255);
                default: ;
            endcase
            do_op("rand", r_op, r_a, r_b, r_rrn, 0, ref_result(r_op, r_a, r_b),
                  ref_lat(r_op, r_a, r_b));
        end

        // Speculative DIV flushed at BUSY cycle 10: no broadcast ever.
        feed(3'd4, 32'd100, 32'd3, 6'd9, 1'b1);
        repeat (9) @(negedge clock);
        bus.delete_tag = 1'b1;
        @(negedge clock);
        bus.delete_tag = 1'b0;
        chk("flush_busy.busy", 32'(bus.busy), 32'd0);
        chk("flush_busy.request", 32'(bus.cdb_request), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.cdb_request) seen = 1'b1;
        end
        chk("flush_busy.no_broadcast", 32'(seen), 32'd0);
        bus.cdb_grant = 1'b1;
        @(negedge clock);
        bus.cdb_grant = 1'b0;

        // Speculative fast-path result flushed while requesting in DONE.
        feed(3'd5, 32'd10, 32'd0, 6'd3, 1'b1);
        chk("flush_done.request_before", 32'(bus.cdb_request), 32'd1);
        bus.delete_tag = 1'b1;
        @(negedge clock);
        bus.delete_tag = 1'b0;
        chk("flush_done.request_after", 32'(bus.cdb_request), 32'd0);
        chk("flush_done.busy_after", 32'(bus.busy), 32'd0);

        // Tagged feed while delete_tag is asserted is refused.
        bus.feed_valid = 1'b1;
        bus.feed_tag   = 1'b1;
        bus.delete_tag = 1'b1;
        #1;
        chk("tagged_feed.next", 32'(bus.next), 32'd0);
        @(negedge clock);
        bus.feed_valid = 1'b0;
        bus.feed_tag   = 1'b0;
        bus.delete_tag = 1'b0;
        chk("tagged_feed.busy", 32'(bus.busy), 32'd0);

        // Non-speculative work ignores delete_tag.
        feed(3'd0, 32'd1234, 32'd5678, 6'd21, 1'b0);
        repeat (4) @(negedge clock);
        bus.delete_tag = 1'b1;
        @(negedge clock);
        bus.delete_tag = 1'b0;
        lat = 0;
        while (!bus.cdb_request && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk("untagged.request", 32'(bus.cdb_request), 32'd1);
        chk("untagged.result", bus.cdb_result, 32'd7006652);
        bus.cdb_grant = 1'b1;
        @(negedge clock);
        bus.cdb_grant = 1'b0;

        // Reset mid-BUSY clears everything; the unit works afterwards.
        feed(3'd0, 32'h1234, 32'h5678, 6'd7, 1'b0);
        repeat (9) @(negedge clock);
        reset          = 1'b0;
        bus.feed_valid = 1'b1;
        @(negedge clock);
        #1;
        chk("midreset.busy", 32'(bus.busy), 32'd0);
        chk("midreset.request", 32'(bus.cdb_request), 32'd0);
        chk("midreset.result", bus.cdb_result, 32'd0);
        chk("midreset.rrn", 32'(bus.cdb_rrn), 32'd0);
        chk("midreset.next", 32'(bus.next), 32'd0);
        @(negedge clock);
        reset          = 1'b1;
        bus.feed_valid = 1'b0;
        @(negedge clock);
        do_op("after_reset", 3'd0, 32'd3, 32'd4, 6'd2, 0, 32'd12, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
